// File: rtl/serial_sub_unit_pkg.sv
// Shared definitions for the bit-serial subtract unit.
package serial_sub_unit_pkg;

  // Encoding 2'd3 is unused and falls back to IDLE in the FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fullSub.sv
// One-bit full subtractor: s0 = a - b - carryIn (mod 2), s1 = borrow out.
module fullSub (
  input  logic a,
  input  logic b,
  input  logic carryIn,
  output logic s1,
  output logic s0
);

  // Pure combinational difference and borrow.
  always_comb begin
    s0 = a ^ b ^ carryIn;
    s1 = (~a & b) | (~a & carryIn) | (b & carryIn);
  end

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial a - b using a single fullSub cell, LSB first, borrow recirculated.
module serial_sub_unit
  import serial_sub_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             brw_q;
  logic [CntW-1:0]  cnt;
  state_e           state;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   diff_q;

  logic brw_n;
  logic d_bit;

  fullSub u_full_sub (
    .a       (a_sr[0]),
    .b       (b_sr[0]),
    .carryIn (brw_q),
    .s1      (brw_n),
    .s0      (d_bit)
  );

  // FSM, shift registers and registered outputs in one clocked process.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw_q  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            brw_q  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          brw_q  <= brw_n;
          cnt    <= cnt + CntW'(1);
          if (cnt == LastCnt) begin
            // Final bit: fold the live cell outputs straight into the result.
            diff_q <= {brw_n, d_bit, res_sr[WIDTH-1:1]};
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = diff_q[WIDTH];

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed self-checking bench for serial_sub_unit (WIDTH = 4).
module tb_serial_sub_unit;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   diff;
  logic         borrow;

  int checks = 0;
  int errors = 0;

  serial_sub_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an op; return edges from the start edge to the done cycle (inclusive).
  // With mid set, a start with different operands is pulsed during SHIFT.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit mid,
                        output int lat);
    a = ta;
    b = tb;
    start = 1'b1;
    step();
    start = 1'b0;
    a = ~ta;
    b = ~tb;
    lat = 1;
    while (!done && lat < 20) begin
      start = mid && (lat == 2);
      step();
      lat++;
    end
    start = 1'b0;
  endtask

  // Leave the done cycle and confirm the return to IDLE.
  task automatic finish_op(input string tag);
    step();
    check_eq({tag, "_done_drop"}, done, 1'b0);
    check_eq({tag, "_busy_drop"}, busy, 1'b0);
  endtask

  int lat;
  int n_done;
  logic [W:0] exp_d;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    reset = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_diff", diff, 5'b00000);
    check_eq("rst_borrow", borrow, 1'b0);

    // 5 - 13 = -8
    run_op(4'b0101, 4'b1101, 1'b0, lat);
    check_eq("t1_lat", lat, 5);
    check_eq("t1_done", done, 1'b1);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_diff", diff, 5'b11000);
    check_eq("t1_borrow", borrow, 1'b1);
    finish_op("t1");
    check_eq("t1_hold", diff, 5'b11000);

    // Reset mid-SHIFT discards the op.
    a = 4'b0001;
    b = 4'b0011;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("mr_busy_pre", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_done", done, 1'b0);
    check_eq("mr_diff", diff, 5'b00000);
    check_eq("mr_borrow", borrow, 1'b0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) n_done++;
    end
    check_eq("mr_no_done", n_done, 0);
    check_eq("mr_idle", busy, 1'b0);
    run_op(4'b1111, 4'b0001, 1'b0, lat);
    check_eq("mr2_lat", lat, 5);
    check_eq("mr2_diff", diff, 5'b01110);
    check_eq("mr2_borrow", borrow, 1'b0);
    finish_op("mr2");

    // Reset and start on the same edge: start dropped.
    reset = 1'b1;
    start = 1'b1;
    a = 4'b0011;
    b = 4'b0001;
    step();
    reset = 1'b0;
    start = 1'b0;
    step();
    check_eq("rs_busy", busy, 1'b0);

    // Back-to-back with a stray start during SHIFT.
    run_op(4'b0000, 4'b0011, 1'b1, lat);
    check_eq("bb1_lat", lat, 5);
    check_eq("bb1_diff", diff, 5'b11101);
    check_eq("bb1_borrow", borrow, 1'b1);
    finish_op("bb1");
    run_op(4'b1000, 4'b1000, 1'b0, lat);
    check_eq("bb2_lat", lat, 5);
    check_eq("bb2_diff", diff, 5'b00000);
    check_eq("bb2_borrow", borrow, 1'b0);
    finish_op("bb2");
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) n_done++;
    end
    check_eq("bb_no_queue", n_done, 0);
    check_eq("bb_idle_busy", busy, 1'b0);

    // Exhaustive sweep against a reference subtraction.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        exp_d = {1'b0, W'(i)} - {1'b0, W'(j)};
        run_op(W'(i), W'(j), 1'b0, lat);
        check_eq($sformatf("sw_lat_%0d_%0d", i, j), lat, 5);
        check_eq($sformatf("sw_diff_%0d_%0d", i, j), diff, exp_d);
        check_eq($sformatf("sw_brw_%0d_%0d", i, j), borrow, (i < j) ? 1'b1 : 1'b0);
        step();
        check_eq($sformatf("sw_pulse_%0d_%0d", i, j), done, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
